// File: rtl/niosii_system_sysid_checker_if.sv
// Avalon-MM read port between the sysid checker and the sysid slave.
// Master drives address/read, slave returns data and stall.
interface niosii_system_sysid_checker_if;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_readdata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_readdata,
    output avm_waitrequest
  );
endinterface

// File: rtl/niosii_system_sysid_checker.sv
// Reads sysid ID and timestamp words and compares them to build-time values.
// Reports pass, mismatch and timeout flags without CPU involvement.
module niosii_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID      = 32'd0,
  parameter logic [31:0] EXPECTED_TS      = 32'd1396263607,
  parameter int          READ_LATENCY     = 0,
  parameter int          TIMEOUT          = 255,
  parameter int          RECHECK_INTERVAL = 0,
  parameter bit          AUTO_START       = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  niosii_system_sysid_checker_if.master avm,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout_err,
  output logic [31:0] read_id,
  output logic [31:0] read_ts,
  output logic [7:0]  check_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ID,
    S_LAT_ID,
    S_RD_TS,
    S_LAT_TS,
    S_COMPARE,
    S_DONE
  } state_t;

  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [1:0]  LAT_LAST = 2'(READ_LATENCY - 1);
  localparam logic [31:0] RC_LAST  = 32'(RECHECK_INTERVAL - 1);
  localparam bit          RC_EN    = (RECHECK_INTERVAL != 0);

  state_t      state_q, state_d;
  logic [15:0] to_q, to_d;
  logic [1:0]  lat_q, lat_d;
  logic [31:0] rc_q, rc_d;
  logic        first_q, first_d;
  logic [31:0] cap_id_q, cap_id_d;
  logic [31:0] cap_ts_q, cap_ts_d;
  logic        idv_q, idv_d;
  logic        tsv_q, tsv_d;
  logic        rd_q, rd_d;
  logic        addr_q, addr_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        idm_q, idm_d;
  logic        tsm_q, tsm_d;
  logic        terr_q, terr_d;
  logic [31:0] rid_q, rid_d;
  logic [31:0] rts_q, rts_d;
  logic [7:0]  cnt_q, cnt_d;

  logic stall;
  logic rc_hit;
  logic trig;
  logic fin_to;
  logic fin_cmp;
  logic [7:0] cnt_inc;

  assign stall   = avm.avm_waitrequest;
  assign rc_hit  = RC_EN && (cnt_q != 8'd0) && (rc_q == RC_LAST);
  assign trig    = start | first_q | rc_hit;
  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  assign avm.avm_read    = rd_q;
  assign avm.avm_address = addr_q;
  assign busy            = (state_q != S_IDLE);
  assign done            = done_q;
  assign pass            = pass_q;
  assign id_mismatch     = idm_q;
  assign ts_mismatch     = tsm_q;
  assign timeout_err     = terr_q;
  assign read_id         = rid_q;
  assign read_ts         = rts_q;
  assign check_count     = cnt_q;

  // Next-state, bus strobes and result updates for the check sequence
  always_comb begin
    state_d  = state_q;
    to_d     = to_q;
    lat_d    = lat_q;
    rc_d     = rc_q;
    first_d  = first_q;
    cap_id_d = cap_id_q;
    cap_ts_d = cap_ts_q;
    idv_d    = idv_q;
    tsv_d    = tsv_q;
    rd_d     = 1'b0;
    addr_d   = 1'b0;
    done_d   = 1'b0;
    pass_d   = pass_q;
    idm_d    = idm_q;
    tsm_d    = tsm_q;
    terr_d   = terr_q;
    rid_d    = rid_q;
    rts_d    = rts_q;
    cnt_d    = cnt_q;
    fin_to   = 1'b0;
    fin_cmp  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (trig) begin
          state_d = S_RD_ID;
          rd_d    = 1'b1;
          to_d    = '0;
          rc_d    = '0;
          first_d = 1'b0;
          idv_d   = 1'b0;
          tsv_d   = 1'b0;
        end else if (RC_EN && cnt_q != 8'd0) begin
          rc_d = rc_q + 32'd1;
        end
      end
      S_RD_ID: begin
        if (stall) begin
          if (to_q == TO_LAST) begin
            fin_to = 1'b1;
          end else begin
            to_d = to_q + 16'd1;
            rd_d = 1'b1;
          end
        end else if (READ_LATENCY == 0) begin
          cap_id_d = avm.avm_readdata;
          idv_d    = 1'b1;
          state_d  = S_RD_TS;
          rd_d     = 1'b1;
          addr_d   = 1'b1;
          to_d     = '0;
        end else begin
          state_d = S_LAT_ID;
          lat_d   = '0;
        end
      end
      S_LAT_ID: begin
        if (lat_q == LAT_LAST) begin
          cap_id_d = avm.avm_readdata;
          idv_d    = 1'b1;
          state_d  = S_RD_TS;
          rd_d     = 1'b1;
          addr_d   = 1'b1;
          to_d     = '0;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      S_RD_TS: begin
        if (stall) begin
          if (to_q == TO_LAST) begin
            fin_to = 1'b1;
          end else begin
            to_d   = to_q + 16'd1;
            rd_d   = 1'b1;
            addr_d = 1'b1;
          end
        end else if (READ_LATENCY == 0) begin
          cap_ts_d = avm.avm_readdata;
          tsv_d    = 1'b1;
          state_d  = S_COMPARE;
        end else begin
          state_d = S_LAT_TS;
          lat_d   = '0;
        end
      end
      S_LAT_TS: begin
        if (lat_q == LAT_LAST) begin
          cap_ts_d = avm.avm_readdata;
          tsv_d    = 1'b1;
          state_d  = S_COMPARE;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      S_COMPARE: begin
        fin_cmp = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (fin_to | fin_cmp) begin
      state_d = S_DONE;
      done_d  = 1'b1;
      cnt_d   = cnt_inc;
    end

    if (fin_to) begin
      terr_d = 1'b1;
      pass_d = 1'b0;
      idm_d  = 1'b0;
      tsm_d  = 1'b0;
      if (idv_q) rid_d = cap_id_q;
      if (tsv_q) rts_d = cap_ts_q;
    end

    if (fin_cmp) begin
      terr_d = 1'b0;
      idm_d  = (cap_id_q != EXPECTED_ID);
      tsm_d  = (cap_ts_q != EXPECTED_TS);
      pass_d = (cap_id_q == EXPECTED_ID) &&
               (cap_ts_q == EXPECTED_TS);
      rid_d  = cap_id_q;
      rts_d  = cap_ts_q;
    end
  end

  // State, counters, bus strobes and results, cleared by synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      to_q     <= '0;
      lat_q    <= '0;
      rc_q     <= '0;
      first_q  <= AUTO_START;
      cap_id_q <= '0;
      cap_ts_q <= '0;
      idv_q    <= 1'b0;
      tsv_q    <= 1'b0;
      rd_q     <= 1'b0;
      addr_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      idm_q    <= 1'b0;
      tsm_q    <= 1'b0;
      terr_q   <= 1'b0;
      rid_q    <= '0;
      rts_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      to_q     <= to_d;
      lat_q    <= lat_d;
      rc_q     <= rc_d;
      first_q  <= first_d;
      cap_id_q <= cap_id_d;
      cap_ts_q <= cap_ts_d;
      idv_q    <= idv_d;
      tsv_q    <= tsv_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      idm_q    <= idm_d;
      tsm_q    <= tsm_d;
      terr_q   <= terr_d;
      rid_q    <= rid_d;
      rts_q    <= rts_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// Bench for the sysid checker: three instances cover default timing,
// slave latency with stall/timeout/reset, and periodic re-checks.
module tb_niosii_system_sysid_checker;

  localparam logic [31:0] EXP_TS = 32'd1396263607;

  typedef struct {
    int          cyc;
    logic        p;
    logic        im;
    logic        tm;
    logic        te;
    logic [31:0] ri;
    logic [31:0] rt;
    logic [7:0]  cn;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;

  logic        a_busy, a_done, a_pass, a_im, a_tm, a_te;
  logic [31:0] a_rid, a_rts;
  logic [7:0]  a_cnt;
  logic        b_busy, b_done, b_pass, b_im, b_tm, b_te;
  logic [31:0] b_rid, b_rts;
  logic [7:0]  b_cnt;
  logic        c_busy, c_done, c_pass, c_im, c_tm, c_te;
  logic [31:0] c_rid, c_rts;
  logic [7:0]  c_cnt;

  niosii_system_sysid_checker_if a_if ();
  niosii_system_sysid_checker_if b_if ();
  niosii_system_sysid_checker_if c_if ();

  // Slave A: zero latency, programmable stall on one address
  logic [31:0] id_a = 32'd0;
  logic [31:0] ts_a = EXP_TS;
  logic        stall_a_addr = 1'b0;
  int          stall_a_lim = 0;
  int          stall_a_cnt = 0;
  logic        wr_a;
  assign wr_a = a_if.avm_read && (a_if.avm_address == stall_a_addr) &&
                (stall_a_cnt < stall_a_lim);
  assign a_if.avm_waitrequest = wr_a;
  assign a_if.avm_readdata = a_if.avm_address ? ts_a : id_a;
  always @(posedge clk) if (wr_a) stall_a_cnt <= stall_a_cnt + 1;

  // Slave B: data valid exactly two cycles after acceptance
  logic        stall_b_addr = 1'b0;
  int          stall_b_lim = 0;
  int          stall_b_cnt = 0;
  logic        wr_b, acc_b;
  logic        p1v = 1'b0, p2v = 1'b0;
  logic [31:0] p1d = 32'd0, p2d = 32'd0;
  assign wr_b = b_if.avm_read && (b_if.avm_address == stall_b_addr) &&
                (stall_b_cnt < stall_b_lim);
  assign acc_b = b_if.avm_read && !wr_b;
  assign b_if.avm_waitrequest = wr_b;
  assign b_if.avm_readdata = p2v ? p2d : 32'hDEADBEEF;
  always @(posedge clk) begin
    if (wr_b) stall_b_cnt <= stall_b_cnt + 1;
    p1v <= acc_b;
    p1d <= b_if.avm_address ? EXP_TS : 32'd0;
    p2v <= p1v;
    p2d <= p1d;
  end

  // Slave C: zero latency, never stalls
  assign c_if.avm_waitrequest = 1'b0;
  assign c_if.avm_readdata = c_if.avm_address ? EXP_TS : 32'd0;

  niosii_system_sysid_checker u_a (
    .clock(clk), .reset(rst_a), .start(start_a), .avm(a_if),
    .busy(a_busy), .done(a_done), .pass(a_pass),
    .id_mismatch(a_im), .ts_mismatch(a_tm), .timeout_err(a_te),
    .read_id(a_rid), .read_ts(a_rts), .check_count(a_cnt)
  );

  niosii_system_sysid_checker #(
    .READ_LATENCY(2), .TIMEOUT(4)
  ) u_b (
    .clock(clk), .reset(rst_b), .start(start_b), .avm(b_if),
    .busy(b_busy), .done(b_done), .pass(b_pass),
    .id_mismatch(b_im), .ts_mismatch(b_tm), .timeout_err(b_te),
    .read_id(b_rid), .read_ts(b_rts), .check_count(b_cnt)
  );

  niosii_system_sysid_checker #(
    .RECHECK_INTERVAL(10)
  ) u_c (
    .clock(clk), .reset(rst_c), .start(start_c), .avm(c_if),
    .busy(c_busy), .done(c_done), .pass(c_pass),
    .id_mismatch(c_im), .ts_mismatch(c_tm), .timeout_err(c_te),
    .read_id(c_rid), .read_ts(c_rts), .check_count(c_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input int c, input logic p, im, tm, te,
                              input logic [31:0] ri, rt,
                              input logic [7:0] cn);
    exp_t e;
    e.cyc = c; e.p = p; e.im = im; e.tm = tm; e.te = te;
    e.ri = ri; e.rt = rt; e.cn = cn;
    return e;
  endfunction

  task automatic cmp_done(input string n, input exp_t e, input logic bz,
                          input logic p, im, tm, te,
                          input logic [31:0] ri, rt,
                          input logic [7:0] cn);
    chk({n, "_done_cyc"}, 32'(cyc), 32'(e.cyc));
    chk({n, "_busy"}, {31'd0, bz}, 32'd1);
    chk({n, "_pass"}, {31'd0, p}, {31'd0, e.p});
    chk({n, "_id_mis"}, {31'd0, im}, {31'd0, e.im});
    chk({n, "_ts_mis"}, {31'd0, tm}, {31'd0, e.tm});
    chk({n, "_timeout"}, {31'd0, te}, {31'd0, e.te});
    chk({n, "_read_id"}, ri, e.ri);
    chk({n, "_read_ts"}, rt, e.rt);
    chk({n, "_count"}, {24'd0, cn}, {24'd0, e.cn});
  endtask

  // Scoreboard pops: one expected result per done pulse
  always @(negedge clk) begin
    if (a_done) begin
      if (qa.size() == 0) chk("A_extra_done", 32'(qa.size()), 32'd1);
      else cmp_done("A", qa.pop_front(), a_busy, a_pass, a_im, a_tm,
                    a_te, a_rid, a_rts, a_cnt);
    end
    if (b_done) begin
      if (qb.size() == 0) chk("B_extra_done", 32'(qb.size()), 32'd1);
      else cmp_done("B", qb.pop_front(), b_busy, b_pass, b_im, b_tm,
                    b_te, b_rid, b_rts, b_cnt);
    end
    if (c_done) begin
      if (qc.size() == 0) chk("C_extra_done", 32'(qc.size()), 32'd1);
      else cmp_done("C", qc.pop_front(), c_busy, c_pass, c_im, c_tm,
                    c_te, c_rid, c_rts, c_cnt);
    end
  end

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  int r;

  initial begin
    repeat (2) @(negedge clk);
    chk("A_rst_busy", {31'd0, a_busy}, 32'd0);
    chk("A_rst_read", {31'd0, a_if.avm_read}, 32'd0);
    chk("A_rst_pass", {31'd0, a_pass}, 32'd0);
    chk("A_rst_count", {24'd0, a_cnt}, 32'd0);
    chk("B_rst_done", {31'd0, b_done}, 32'd0);
    chk("C_rst_read_ts", c_rts, 32'd0);

    // A: auto-start after reset, default timing
    r = cyc;
    qa.push_back(mk(r + 4, 1, 0, 0, 0, 32'd0, EXP_TS, 8'd1));
    rst_a = 1'b0;
    wait_to(r + 1);
    chk("A_rd_id_read", {31'd0, a_if.avm_read}, 32'd1);
    chk("A_rd_id_addr", {31'd0, a_if.avm_address}, 32'd0);
    wait_to(r + 2);
    chk("A_rd_ts_read", {31'd0, a_if.avm_read}, 32'd1);
    chk("A_rd_ts_addr", {31'd0, a_if.avm_address}, 32'd1);
    start_a = 1'b1;
    wait_to(r + 3);
    start_a = 1'b0;
    chk("A_cmp_read", {31'd0, a_if.avm_read}, 32'd0);
    chk("A_cmp_addr", {31'd0, a_if.avm_address}, 32'd0);
    chk("A_cmp_busy", {31'd0, a_busy}, 32'd1);
    wait_to(r + 7);
    chk("A_idle_busy", {31'd0, a_busy}, 32'd0);
    chk("A_idle_count", {24'd0, a_cnt}, 32'd1);

    // A: ID mismatch, old results held while busy
    r = cyc;
    id_a = 32'd1;
    start_a = 1'b1;
    qa.push_back(mk(r + 4, 0, 1, 0, 0, 32'd1, EXP_TS, 8'd2));
    wait_to(r + 1);
    start_a = 1'b0;
    wait_to(r + 2);
    chk("A_hold_pass", {31'd0, a_pass}, 32'd1);
    wait_to(r + 7);

    // A: timestamp mismatch
    r = cyc;
    id_a = 32'd0;
    ts_a = EXP_TS ^ 32'd1;
    start_a = 1'b1;
    qa.push_back(mk(r + 4, 0, 0, 1, 0, 32'd0, EXP_TS ^ 32'd1, 8'd3));
    wait_to(r + 1);
    start_a = 1'b0;
    wait_to(r + 7);

    // A: two waitrequest cycles on the ID read
    r = cyc;
    ts_a = EXP_TS;
    stall_a_addr = 1'b0;
    stall_a_lim = stall_a_cnt + 2;
    start_a = 1'b1;
    qa.push_back(mk(r + 6, 1, 0, 0, 0, 32'd0, EXP_TS, 8'd4));
    wait_to(r + 1);
    start_a = 1'b0;
    wait_to(r + 2);
    chk("A_stall_read", {31'd0, a_if.avm_read}, 32'd1);
    chk("A_stall_addr", {31'd0, a_if.avm_address}, 32'd0);
    wait_to(r + 9);

    // A: start coinciding with auto-start yields one check
    rst_a = 1'b1;
    @(negedge clk);
    chk("A_rst2_count", {24'd0, a_cnt}, 32'd0);
    chk("A_rst2_pass", {31'd0, a_pass}, 32'd0);
    r = cyc;
    rst_a = 1'b0;
    start_a = 1'b1;
    qa.push_back(mk(r + 4, 1, 0, 0, 0, 32'd0, EXP_TS, 8'd1));
    @(negedge clk);
    start_a = 1'b0;
    wait_to(r + 9);
    chk("A_single_count", {24'd0, a_cnt}, 32'd1);

    // B: latency 2, three stalls on the timestamp read
    r = cyc;
    stall_b_addr = 1'b1;
    stall_b_lim = stall_b_cnt + 3;
    qb.push_back(mk(r + 11, 1, 0, 0, 0, 32'd0, EXP_TS, 8'd1));
    rst_b = 1'b0;
    wait_to(r + 1);
    chk("B_rd_id_read", {31'd0, b_if.avm_read}, 32'd1);
    wait_to(r + 2);
    chk("B_lat_read", {31'd0, b_if.avm_read}, 32'd0);
    chk("B_lat_addr", {31'd0, b_if.avm_address}, 32'd0);
    wait_to(r + 4);
    chk("B_rd_ts_read", {31'd0, b_if.avm_read}, 32'd1);
    chk("B_rd_ts_addr", {31'd0, b_if.avm_address}, 32'd1);
    wait_to(r + 6);
    chk("B_stall_read", {31'd0, b_if.avm_read}, 32'd1);
    wait_to(r + 13);

    // B: waitrequest stuck on ID read -> timeout after 4 stalls
    r = cyc;
    stall_b_addr = 1'b0;
    stall_b_lim = stall_b_cnt + 1000;
    start_b = 1'b1;
    qb.push_back(mk(r + 5, 0, 0, 0, 1, 32'd0, EXP_TS, 8'd2));
    wait_to(r + 1);
    start_b = 1'b0;
    wait_to(r + 4);
    chk("B_to_held_read", {31'd0, b_if.avm_read}, 32'd1);
    wait_to(r + 5);
    chk("B_to_drop_read", {31'd0, b_if.avm_read}, 32'd0);
    stall_b_lim = stall_b_cnt;
    wait_to(r + 7);

    // B: normal check clears timeout flag
    r = cyc;
    start_b = 1'b1;
    qb.push_back(mk(r + 8, 1, 0, 0, 0, 32'd0, EXP_TS, 8'd3));
    wait_to(r + 1);
    start_b = 1'b0;
    wait_to(r + 10);

    // B: reset during LAT_TS, then auto re-check
    r = cyc;
    start_b = 1'b1;
    wait_to(r + 1);
    start_b = 1'b0;
    wait_to(r + 5);
    rst_b = 1'b1;
    wait_to(r + 6);
    chk("B_mid_read", {31'd0, b_if.avm_read}, 32'd0);
    chk("B_mid_busy", {31'd0, b_busy}, 32'd0);
    chk("B_mid_done", {31'd0, b_done}, 32'd0);
    chk("B_mid_pass", {31'd0, b_pass}, 32'd0);
    chk("B_mid_count", {24'd0, b_cnt}, 32'd0);
    chk("B_mid_read_ts", b_rts, 32'd0);
    r = cyc;
    rst_b = 1'b0;
    qb.push_back(mk(r + 8, 1, 0, 0, 0, 32'd0, EXP_TS, 8'd1));
    wait_to(r + 10);

    // C: periodic re-checks 14 cycles apart, start while busy dropped
    r = cyc;
    qc.push_back(mk(r + 4, 1, 0, 0, 0, 32'd0, EXP_TS, 8'd1));
    qc.push_back(mk(r + 18, 1, 0, 0, 0, 32'd0, EXP_TS, 8'd2));
    qc.push_back(mk(r + 32, 1, 0, 0, 0, 32'd0, EXP_TS, 8'd3));
    rst_c = 1'b0;
    wait_to(r + 16);
    chk("C_busy_start", {31'd0, c_busy}, 32'd1);
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    wait_to(r + 33);
    chk("C_count", {24'd0, c_cnt}, 32'd3);
    chk("C_idle", {31'd0, c_busy}, 32'd0);
    rst_c = 1'b1;
    repeat (2) @(negedge clk);

    chk("A_pending", 32'(qa.size()), 32'd0);
    chk("B_pending", 32'(qb.size()), 32'd0);
    chk("C_pending", 32'(qc.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/niosii_system_sysid_checker.md
# niosII_system_sysid_checker

Avalon-MM master that sits directly downstream of the system-ID slave in the Nios II system. After reset, on request, or periodically, it reads the ID word (address 0) and the timestamp word (address 1), compares both against build-time expected values, and reports pass/fail and timeout status. The flags give the rest of the design a hardware "correct bitstream / correct software image" check without CPU involvement.

## Interface
- EXPECTED_ID, 32'd0, expected word at address 0
- EXPECTED_TS, 32'd1396263607, expected word at address 1
- READ_LATENCY, 0, fixed slave read latency in cycles (0..3)
- TIMEOUT, 255, max cycles a read may be held off by waitrequest (1..65535)
- RECHECK_INTERVAL, 0, idle cycles between automatic re-checks; 0 = disabled
- AUTO_START, 1, 1 = begin a check on the first cycle after reset deasserts
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request for a check; ignored while busy
- avm_address  out  1  word address to sysid slave
- avm_read  out  1  read strobe
- avm_readdata  in  32  read data from sysid slave
- avm_waitrequest  in  1  slave stall
- busy  out  1  check in progress
- done  out  1  one-cycle pulse at check completion
- pass  out  1  last check matched both words
- id_mismatch  out  1  last captured ID != EXPECTED_ID
- ts_mismatch  out  1  last captured timestamp != EXPECTED_TS
- timeout_err  out  1  last check aborted by timeout
- read_id  out  32  last captured ID word
- read_ts  out  32  last captured timestamp word
- check_count  out  8  completed checks, saturating at 255

## Operation
- States: IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, COMPARE, DONE.
- IDLE: a trigger moves the FSM to RD_ID. Triggers are start=1, the first cycle after reset when AUTO_START=1, or recheck counter == RECHECK_INTERVAL. The recheck counter counts only in IDLE, only after at least one completed check, and clears on any trigger.
- RD_ID/RD_TS: avm_read=1, avm_address=0 or 1 respectively, held stable until accepted (avm_read & !avm_waitrequest).
  - READ_LATENCY=0: capture avm_readdata in the accepting cycle, then go to the next read state (RD_ID→RD_TS, RD_TS→COMPARE).
  - READ_LATENCY>0: on acceptance drop avm_read and go to LAT_x. Count READ_LATENCY cycles, capture on the last one, then proceed.
- Timeout counter: clears on entry to each RD_x state and increments each cycle avm_waitrequest=1. When it reaches TIMEOUT, drop avm_read and go to DONE with timeout_err=1, pass=0, and both mismatch flags=0. read_id/read_ts keep only the words actually captured.
- COMPARE: register id_mismatch, ts_mismatch, and pass = !(id_mismatch|ts_mismatch); timeout_err=0.
- DONE: done=1 for one cycle, check_count increments (saturating), then return to IDLE.
- Result outputs (pass, mismatch flags, timeout_err, read_id, read_ts) hold until the next DONE. They are not cleared when a new check starts.
- busy=1 in every state except IDLE.
- start while busy is dropped and not queued. start coinciding with an auto/recheck trigger yields one check.

## Timing
- Reset values: all outputs 0, FSM in IDLE, all counters 0. With AUTO_START=1 the first trigger is taken in the first cycle with reset=0.
- Reset asserted mid-check: at the next edge, avm_read=0, outputs return to reset values, and no done pulse is generated.
- Trigger sampled in cycle T, with READ_LATENCY=L and no waitrequest:
  - RD_ID in T+1.
  - RD_TS in T+2+L.
  - COMPARE in T+3+2L.
  - done=1 with new results visible in T+4+2L.
- Each waitrequest cycle adds one cycle.
- avm_address and avm_read are registered outputs. avm_address is 0 whenever avm_read=0.

## Test plan
- Default params, slave returns 0 / 1396263607, waitrequest=0, reset released at cycle 0 → read addr0 cycle 1, addr1 cycle 2, done cycle 4, pass=1, check_count=1.
- Slave returns 0x00000001 at addr0 → done with pass=0, id_mismatch=1, ts_mismatch=0, read_id=1.
- READ_LATENCY=2, waitrequest high for 3 cycles on addr1 → done at trigger+11, read_ts captured exactly 2 cycles after acceptance, pass=1.
- TIMEOUT=4, waitrequest stuck high on addr0 → avm_read drops after 4 stalled cycles, done pulse, timeout_err=1, pass=0.
- RECHECK_INTERVAL=10, AUTO_START=1 → periodic checks, consecutive done pulses 14 cycles apart (10 idle + 4). start during busy is ignored, so check_count advances by one per check.
- reset asserted during LAT_TS → next cycle all outputs 0, no done. After release, AUTO_START re-runs the check and passes.
